// File: rtl/gift_drop_engine.sv
// Multi-slot falling power-up engine: LFSR-chosen kinds, per-slot IDLE/FALL/CAUGHT
// state machines, and a catch arbiter that feeds a valid/ready kind queue.
module gift_drop_engine #(
  parameter int unsigned SLOTS     = 4,
  parameter int unsigned W         = 10,
  parameter int unsigned FALL_STEP = 2,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned GIFT_W    = 16,
  parameter int unsigned GIFT_H    = 8,
  parameter int unsigned PD_W      = 64,
  parameter int unsigned PD_SZ     = 10,
  parameter int unsigned Q_DEPTH   = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               lost,
  input  logic               spawn,
  input  logic [W-1:0]       spawn_x,
  input  logic [W-1:0]       spawn_y,
  input  logic [W-1:0]       paddle_x,
  input  logic [W-1:0]       paddle_y,
  output logic [SLOTS*W-1:0] o_x,
  output logic [SLOTS*W-1:0] o_y,
  output logic [SLOTS*3-1:0] o_kind,
  output logic [SLOTS-1:0]   active,
  output logic               spawn_drop,
  output logic               catch_valid,
  output logic [2:0]         catch_kind,
  input  logic               catch_ready
);

  localparam int unsigned EW = W + 2;
  localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [EW-1:0] FS_E  = EW'(FALL_STEP);
  localparam logic [EW-1:0] SH_E  = EW'(SCREEN_H);
  localparam logic [EW-1:0] GW_E  = EW'(GIFT_W);
  localparam logic [EW-1:0] GH_E  = EW'(GIFT_H);
  localparam logic [EW-1:0] PDW_E = EW'(PD_W);
  localparam logic [EW-1:0] PSZ_E = EW'(PD_SZ);

  typedef enum logic [1:0] {S_IDLE, S_FALL, S_CAUGHT} slot_st_e;

  slot_st_e       st_q [SLOTS];
  slot_st_e       st_d [SLOTS];
  logic [W-1:0]   x_q [SLOTS], x_d [SLOTS];
  logic [W-1:0]   y_q [SLOTS], y_d [SLOTS];
  logic [2:0]     k_q [SLOTS], k_d [SLOTS];
  logic [SLOTS-1:0] active_q, active_d;
  logic           spawn_drop_q, spawn_drop_d;
  logic [15:0]    lfsr_q, lfsr_d;

  logic [2:0]     mem_q [Q_DEPTH], mem_d [Q_DEPTH];
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [2:0]     head_q, head_d;

  logic           pop, full, push, arb_done, taken, hit, miss;
  logic [2:0]     push_kind;
  logic [EW-1:0]  yn;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign catch_valid = (cnt_q != '0);
  assign catch_kind  = head_q;
  assign active      = active_q;
  assign spawn_drop  = spawn_drop_q;
  assign pop         = catch_valid & catch_ready;
  assign full        = (cnt_q == (PW+1)'(Q_DEPTH));

  always_comb begin
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    st_d         = st_q;
    x_d          = x_q;
    y_d          = y_q;
    k_d          = k_q;
    mem_d        = mem_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    head_d       = head_q;
    spawn_drop_d = 1'b0;
    push         = 1'b0;
    push_kind    = '0;
    arb_done     = 1'b0;
    taken        = 1'b0;
    yn           = '0;
    hit          = 1'b0;
    miss         = 1'b0;
    if (lost) begin
      for (int unsigned i = 0; i < SLOTS; i++) st_d[i] = S_IDLE;
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      head_d = '0;
    end else begin
      // A full queue still accepts a push when the head is leaving this cycle.
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (!arb_done && st_q[i] == S_CAUGHT) begin
          arb_done = 1'b1;
          if (!full || pop) begin
            push      = 1'b1;
            push_kind = k_q[i];
            st_d[i]   = S_IDLE;
          end
        end
      end
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (tick && st_q[i] == S_FALL) begin
          yn   = {2'b00, y_q[i]} + FS_E;
          hit  = ({2'b00, x_q[i]} + GW_E > {2'b00, paddle_x}) &&
                 ({2'b00, x_q[i]} < {2'b00, paddle_x} + PDW_E) &&
                 (yn + GH_E >= {2'b00, paddle_y}) &&
                 (yn <= {2'b00, paddle_y} + PSZ_E);
          miss = (yn + GH_E >= SH_E) || yn[W];
          if (hit)       st_d[i] = S_CAUGHT;
          else if (miss) st_d[i] = S_IDLE;
          else           y_d[i]  = yn[W-1:0];
        end
      end
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (spawn && !taken && st_q[i] == S_IDLE) begin
          taken   = 1'b1;
          st_d[i] = S_FALL;
          x_d[i]  = spawn_x;
          y_d[i]  = spawn_y;
          k_d[i]  = lfsr_q[2:0];
        end
      end
      if (spawn && !taken) spawn_drop_d = 1'b1;
      if (pop) rd_d = ptr_inc(rd_q);
      if (push) begin
        mem_d[wr_q] = push_kind;
        wr_d        = ptr_inc(wr_q);
      end
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      // Head register tracks the next-cycle head so catch_kind stays registered.
      if (cnt_d == '0)
        head_d = '0;
      else if (push && (cnt_q == '0 || (cnt_q == (PW+1)'(1) && pop)))
        head_d = push_kind;
      else
        head_d = mem_q[rd_d];
    end
    for (int unsigned i = 0; i < SLOTS; i++) active_d[i] = (st_d[i] == S_FALL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        st_q[i] <= S_IDLE;
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        k_q[i]  <= '0;
      end
      for (int unsigned j = 0; j < Q_DEPTH; j++) mem_q[j] <= '0;
      active_q     <= '0;
      spawn_drop_q <= 1'b0;
      lfsr_q       <= SEED_EFF;
      rd_q         <= '0;
      wr_q         <= '0;
      cnt_q        <= '0;
      head_q       <= '0;
    end else begin
      st_q         <= st_d;
      x_q          <= x_d;
      y_q          <= y_d;
      k_q          <= k_d;
      mem_q        <= mem_d;
      active_q     <= active_d;
      spawn_drop_q <= spawn_drop_d;
      lfsr_q       <= lfsr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      head_q       <= head_d;
    end
  end

  always_comb begin
    o_x    = '0;
    o_y    = '0;
    o_kind = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      o_x[i*W +: W]    = x_q[i];
      o_y[i*W +: W]    = y_q[i];
      o_kind[i*3 +: 3] = k_q[i];
    end
  end

endmodule

// File: tb/tb_gift_drop_engine.sv
// Directed bench for gift_drop_engine: inline checks on slot state plus a
// scoreboard of expected catch kinds popped by a handshake monitor.
module tb_gift_drop_engine;
  localparam int W = 10;
  localparam int S = 4;

  logic           clock = 1'b0;
  logic           reset, tick, lost, spawn, catch_ready;
  logic [W-1:0]   spawn_x, spawn_y, paddle_x, paddle_y;
  logic [S*W-1:0] o_x, o_y;
  logic [S*3-1:0] o_kind;
  logic [S-1:0]   active;
  logic           spawn_drop, catch_valid;
  logic [2:0]     catch_kind;

  int checks = 0;
  int errors = 0;
  logic [2:0]  sb[$];
  logic [15:0] m;

  gift_drop_engine #(.SLOTS(S), .W(W), .SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset), .tick(tick), .lost(lost), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .paddle_x(paddle_x), .paddle_y(paddle_y),
    .o_x(o_x), .o_y(o_y), .o_kind(o_kind), .active(active), .spawn_drop(spawn_drop),
    .catch_valid(catch_valid), .catch_kind(catch_kind), .catch_ready(catch_ready)
  );

  always #5 clock = ~clock;

  // Reference LFSR: right shift, XOR taps when the dropped bit is 1.
  always @(posedge clock or negedge reset) begin
    if (!reset) m <= 16'hACE1;
    else        m <= (m >> 1) ^ ({16{m[0]}} & 16'hB400);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && catch_valid && catch_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL catch_pop: got kind %0d expected no entry", catch_kind);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        if (catch_kind !== e) begin
          errors++;
          $display("FAIL catch_pop: got kind %0d expected %0d", catch_kind, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] fy(input int i);
    return o_y[i*W +: W];
  endfunction
  function automatic logic [W-1:0] fx(input int i);
    return o_x[i*W +: W];
  endfunction
  function automatic logic [2:0] fk(input int i);
    return o_kind[i*3 +: 3];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_spawn(input logic [W-1:0] x, input logic [W-1:0] y, input logic t,
                          output logic [2:0] k);
    spawn = 1'b1; spawn_x = x; spawn_y = y; tick = t;
    k = m[2:0];
    step();
    spawn = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] k, k0, k1, k2, k3, q0, q1, q2, q3, q4, q5, dummy;
    int n;
    reset = 1'b0; tick = 1'b0; lost = 1'b0; spawn = 1'b0; catch_ready = 1'b0;
    spawn_x = '0; spawn_y = '0; paddle_x = 10'd400; paddle_y = 10'd300;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_active", active, 0);
    chk("rst_ox", o_x, 0);
    chk("rst_valid", catch_valid, 0);
    reset = 1'b1;
    chk("rel_oy", o_y, 0);
    chk("rel_kind", o_kind, 0);
    chk("rel_drop", spawn_drop, 0);

    // spawn and fall to the screen bottom
    do_spawn(10'd100, 10'd50, 1'b0, k);
    chk("sp_active", active, 4'b0001);
    chk("sp_x", fx(0), 100);
    chk("sp_y", fy(0), 50);
    chk("sp_kind_seed", fk(0), 3'd1);
    chk("sp_kind_model", fk(0), k);
    do_tick(10);
    chk("fall10_y", fy(0), 70);
    n = 0;
    tick = 1'b1;
    while (active[0] && n < 300) begin
      step();
      n++;
    end
    tick = 1'b0;
    chk("miss_ticks", n, 201);
    chk("miss_valid", catch_valid, 0);

    // catch just below the boundary, then held head
    paddle_x = 10'd90; paddle_y = 10'd100;
    do_spawn(10'd100, 10'd89, 1'b0, k);
    do_tick(1);
    chk("nearmiss_active", active[0], 1);
    chk("nearmiss_y", fy(0), 91);
    sb.push_back(k);
    do_tick(1);
    chk("caught_active", active[0], 0);
    chk("caught_frozen_y", fy(0), 91);
    chk("caught_valid0", catch_valid, 0);
    step();
    chk("catch_valid", catch_valid, 1);
    chk("catch_kind", catch_kind, k);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_kind", catch_kind, k);
    end
    catch_ready = 1'b1;
    step();
    catch_ready = 1'b0;
    chk("popped_valid", catch_valid, 0);
    paddle_x = 10'd400; paddle_y = 10'd300;

    // fill slots, spawn+tick, drop
    do_spawn(10'd20, 10'd20, 1'b1, k0);
    chk("sptick_y0", fy(0), 20);
    do_spawn(10'd40, 10'd30, 1'b1, k1);
    chk("sptick_y0b", fy(0), 22);
    chk("sptick_y1", fy(1), 30);
    do_spawn(10'd60, 10'd40, 1'b0, k2);
    do_spawn(10'd80, 10'd60, 1'b0, k3);
    chk("full_active", active, 4'hF);
    chk("full_kind", o_kind, {k3, k2, k1, k0});
    do_spawn(10'd200, 10'd200, 1'b0, dummy);
    chk("drop_pulse", spawn_drop, 1);
    chk("drop_active", active, 4'hF);
    chk("drop_x", o_x, {10'd80, 10'd60, 10'd40, 10'd20});
    chk("drop_y", o_y, {10'd60, 10'd40, 10'd30, 10'd22});
    step();
    chk("drop_end", spawn_drop, 0);

    // queue full with waiting caught slots
    lost = 1'b1;
    step();
    lost = 1'b0;
    chk("lost_clear", active, 0);
    do_spawn(10'd20, 10'd50, 1'b0, q0);
    do_spawn(10'd40, 10'd50, 1'b0, q1);
    do_spawn(10'd60, 10'd50, 1'b0, q2);
    do_spawn(10'd80, 10'd50, 1'b0, q3);
    paddle_x = 10'd20; paddle_y = 10'd60;
    sb.push_back(q0); sb.push_back(q1); sb.push_back(q2); sb.push_back(q3);
    do_tick(1);
    chk("all_caught", active, 0);
    repeat (4) step();
    do_spawn(10'd20, 10'd50, 1'b0, q4);
    do_spawn(10'd40, 10'd50, 1'b0, q5);
    sb.push_back(q4); sb.push_back(q5);
    do_tick(1);
    repeat (3) step();
    chk("wait_active", active, 0);
    chk("wait_valid", catch_valid, 1);
    chk("wait_head", catch_kind, q0);
    catch_ready = 1'b1;
    step();
    catch_ready = 1'b0;
    step();
    chk("refill_head", catch_kind, q1);
    catch_ready = 1'b1;
    repeat (8) step();
    catch_ready = 1'b0;
    chk("drain_valid", catch_valid, 0);
    chk("drain_sb", sb.size(), 0);

    // lost with queued catches, falling gifts and a spawn
    do_spawn(10'd20, 10'd50, 1'b0, dummy);
    do_spawn(10'd40, 10'd50, 1'b0, dummy);
    do_tick(1);
    repeat (2) step();
    paddle_x = 10'd400; paddle_y = 10'd300;
    do_spawn(10'd100, 10'd100, 1'b0, dummy);
    do_spawn(10'd120, 10'd100, 1'b0, dummy);
    do_spawn(10'd140, 10'd100, 1'b0, dummy);
    do_spawn(10'd160, 10'd100, 1'b0, dummy);
    chk("prelost_active", active, 4'hF);
    chk("prelost_valid", catch_valid, 1);
    lost = 1'b1; spawn = 1'b1; tick = 1'b1; spawn_x = 10'd200;
    step();
    lost = 1'b0; spawn = 1'b0; tick = 1'b0;
    chk("lost_active", active, 0);
    chk("lost_valid", catch_valid, 0);
    chk("lost_drop", spawn_drop, 0);
    chk("lost_kind", catch_kind, 0);
    catch_ready = 1'b1;
    repeat (2) step();
    catch_ready = 1'b0;
    do_spawn(10'd300, 10'd100, 1'b0, k);
    chk("post_lost_x", fx(0), 300);
    chk("post_lost_kind", fk(0), k);

    // asynchronous reset mid-operation
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_active", active, 0);
    chk("mid_rst_x", o_x, 0);
    chk("mid_rst_kind", o_kind, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    do_spawn(10'd5, 10'd5, 1'b0, k);
    chk("rerst_kind", fk(0), 3'd1);
    chk("rerst_active", active, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
